ahb_apb_bridge_responder: RTL and testbench

//  AHB-side slave responder of the AHB-to-APB bridge. Answers the AHB master on HREADYout/HRESP/HRDATA.

---
 rtl/ahb_apb_bridge_responder_if.sv | 43 ++++
 rtl/ahb_apb_bridge_responder.sv | 152 +++++++++++++++
 tb/tb_ahb_apb_bridge_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_bridge_responder_if.sv
// Bus bundle between the AHB master, the bridge responder and the APB peripherals.
// The optional PREADY wire exists only when APB_PREADY_EN is defined.
interface ahb_apb_bridge_responder_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic              HSELAPBif;
  logic [1:0]        HTRANs;
  logic              HWRITE;
  logic              HREADYin;
  logic [2:0]        HSIZE;
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYout;
  logic [1:0]        HRESP;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic [NUM_SLV-1:0] PSELx;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
`ifdef APB_PREADY_EN
  logic              PREADY;
`endif

  modport slave (
`ifdef APB_PREADY_EN
    input  PREADY,
`endif
    input  HSELAPBif, HTRANs, HWRITE, HREADYin, HSIZE, HADDR, HWDATA, PRDATA,
    output HRDATA, HREADYout, HRESP, PADDR, PWDATA, PWRITE, PSELx, PENABLE
  );

  modport master (
`ifdef APB_PREADY_EN
    output PREADY,
`endif
    output HSELAPBif, HTRANs, HWRITE, HREADYin, HSIZE, HADDR, HWDATA, PRDATA,
    input  HRDATA, HREADYout, HRESP, PADDR, PWDATA, PWRITE, PSELx, PENABLE
  );
endinterface

// File: rtl/ahb_apb_bridge_responder.sv
// AHB slave side of an AHB-to-APB bridge: one APB SETUP/ENABLE access per accepted AHB transfer.
// Optional feature macro: APB_PREADY_EN (ENABLE waits for PREADY from the peripheral).
module ahb_apb_bridge_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 28
) (
  input  logic       HCLK,
  input  logic       HRESET,
  ahb_apb_bridge_responder_if.slave bus,
  output logic [2:0] dbg_state
);
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETUP  = 3'd2,
    S_ENABLE = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [SEL_W-1:0]    idx_q;
  logic [DATA_W-1:0]   hrdata_q;
  logic                hready_q;
  logic [1:0]          hresp_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pwrite_q;
  logic [NUM_SLV-1:0]  psel_q;
  logic                penable_q;

  // Handshake: an address phase is accepted when valid is high at a posedge while
  // HREADYout is high (IDLE, DONE or ERR2); HREADYout low stretches the data phase.
  logic                valid;
  logic [ADDR_W-1:0]   sel_field;
  logic                bad_xfer;

  assign valid     = bus.HSELAPBif && bus.HREADYin &&
                     ((bus.HTRANs == TR_NONSEQ) || (bus.HTRANs == TR_SEQ));
  // Every address bit from SEL_LSB upward belongs to the slave number, so decodes
  // beyond the last peripheral (e.g. 0x5000_0000) are answered with ERROR.
  assign sel_field = bus.HADDR >> SEL_LSB;
  assign bad_xfer  = (sel_field >= ADDR_W'(NUM_SLV)) || (bus.HSIZE > 3'b010);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      hrdata_q  <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= RESP_OKAY;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR2: begin
          if (valid) begin
            addr_q   <= bus.HADDR;
            write_q  <= bus.HWRITE;
            idx_q    <= sel_field[SEL_W-1:0];
            hready_q <= 1'b0;
            if (bad_xfer) begin
              state   <= S_ERR1;
              hresp_q <= RESP_ERROR;
            end else begin
              state   <= S_WAIT;
              hresp_q <= RESP_OKAY;
            end
          end else begin
            state    <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
          end
        end

        S_WAIT: begin
          state     <= S_SETUP;
          paddr_q   <= addr_q;
          pwrite_q  <= write_q;
          if (write_q) begin
            pwdata_q <= bus.HWDATA;
          end
          psel_q    <= NUM_SLV'(1) << idx_q;
          penable_q <= 1'b0;
        end

        S_SETUP: begin
          state     <= S_ENABLE;
          penable_q <= 1'b1;
        end

        S_ENABLE: begin
`ifdef APB_PREADY_EN
          if (bus.PREADY) begin
`else
          begin
`endif
            state     <= S_DONE;
            if (!write_q) begin
              hrdata_q <= bus.PRDATA;
            end
            psel_q    <= '0;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
            hresp_q   <= RESP_OKAY;
          end
        end

        S_ERR1: begin
          state    <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= RESP_ERROR;
        end

        default: begin
          state     <= S_IDLE;
          hready_q  <= 1'b1;
          hresp_q   <= RESP_OKAY;
          psel_q    <= '0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYout = hready_q;
  assign bus.HRESP     = hresp_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSELx     = psel_q;
  assign bus.PENABLE   = penable_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ahb_apb_bridge_responder.sv
// Directed plus randomized bench for ahb_apb_bridge_responder against a transfer-level model.
module tb_ahb_apb_bridge_responder;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 4;
  localparam int SEL_LSB = 28;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         checks;
  int         failures;
  logic [DATA_W-1:0] exp_rdata;
  logic [DATA_W-1:0] exp_pwdata;

  ahb_apb_bridge_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

  ahb_apb_bridge_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .SEL_LSB(SEL_LSB)
  ) dut (
    .HCLK(clk),
    .HRESET(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.HSELAPBif = 1'b0;
    bus.HTRANs    = 2'b00;
    bus.HREADYin  = 1'b1;
  endtask

  // Called just after a negedge; the following posedge samples the address phase.
  task automatic addr_phase(input logic [31:0] a, input bit w, input logic [2:0] sz,
                            input logic [1:0] tr);
    bus.HSELAPBif = 1'b1;
    bus.HREADYin  = 1'b1;
    bus.HTRANs    = tr;
    bus.HADDR     = a;
    bus.HWRITE    = w;
    bus.HSIZE     = sz;
    @(posedge clk);
  endtask

  // Follows an accepted address phase and ends at the negedge of the final data cycle.
  task automatic data_phase(input logic [31:0] a, input bit w, input logic [2:0] sz,
                            input logic [31:0] wd, input logic [31:0] rd, input int stall);
    int idx;
    bit err;
    logic [NUM_SLV-1:0] exp_sel;
    idx     = int'(a >> SEL_LSB);
    err     = (idx >= NUM_SLV) || (sz > 3'd2);
    exp_sel = NUM_SLV'(1) << idx;
    @(negedge clk);
    drive_idle();
    bus.HWDATA = wd;
    bus.PRDATA = rd;
    check("dp1_hready", bus.HREADYout, 0);
    check("dp1_hresp", bus.HRESP, err ? 2'b01 : 2'b00);
    check("dp1_psel", bus.PSELx, 0);
    if (err) begin
      @(negedge clk);
      check("err2_hready", bus.HREADYout, 1);
      check("err2_hresp", bus.HRESP, 2'b01);
      check("err2_psel", bus.PSELx, 0);
      check("err2_penable", bus.PENABLE, 0);
      check("err2_hrdata", bus.HRDATA, exp_rdata);
      return;
    end
    if (w) exp_pwdata = wd;
    @(negedge clk);
    check("setup_hready", bus.HREADYout, 0);
    check("setup_psel", bus.PSELx, exp_sel);
    check("setup_penable", bus.PENABLE, 0);
    check("setup_paddr", bus.PADDR, a);
    check("setup_pwrite", bus.PWRITE, w);
    check("setup_pwdata", bus.PWDATA, exp_pwdata);
    @(negedge clk);
`ifdef APB_PREADY_EN
    bus.PREADY = (stall == 0);
`endif
    check("enable_hready", bus.HREADYout, 0);
    check("enable_psel", bus.PSELx, exp_sel);
    check("enable_penable", bus.PENABLE, 1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_hready", bus.HREADYout, 0);
      check("stall_psel", bus.PSELx, exp_sel);
      check("stall_penable", bus.PENABLE, 1);
      check("stall_paddr", bus.PADDR, a);
      check("stall_pwdata", bus.PWDATA, exp_pwdata);
`ifdef APB_PREADY_EN
      if (s == stall - 1) bus.PREADY = 1'b1;
`endif
    end
    if (!w) exp_rdata = rd;
    @(negedge clk);
    check("done_hready", bus.HREADYout, 1);
    check("done_hresp", bus.HRESP, 2'b00);
    check("done_psel", bus.PSELx, 0);
    check("done_penable", bus.PENABLE, 0);
    check("done_hrdata", bus.HRDATA, exp_rdata);
  endtask

  // One non-accepted cycle: deselected, BUSY, stalled by HREADYin, or IDLE.
  task automatic idle_cycle(input int kind);
    drive_idle();
    bus.HADDR  = $urandom;
    bus.HWRITE = 1'($urandom_range(0, 1));
    case (kind)
      0: bus.HTRANs = 2'b10;
      1: begin bus.HSELAPBif = 1'b1; bus.HTRANs = 2'b01; end
      2: begin bus.HSELAPBif = 1'b1; bus.HTRANs = 2'b10; bus.HREADYin = 1'b0; end
      default: bus.HTRANs = 2'b00;
    endcase
    @(negedge clk);
    drive_idle();
    check("idle_hready", bus.HREADYout, 1);
    check("idle_hresp", bus.HRESP, 2'b00);
    check("idle_psel", bus.PSELx, 0);
  endtask

  initial begin
    logic [31:0] a, wd, rd;
    bit w;
    logic [2:0] sz;
    int stall;
    checks = 0;
    failures = 0;
    exp_rdata = '0;
    exp_pwdata = '0;
    drive_idle();
    bus.HADDR = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010;
    bus.HWDATA = '0;
    bus.PRDATA = '0;
`ifdef APB_PREADY_EN
    bus.PREADY = 1'b1;
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hready", bus.HREADYout, 1);
    check("rst_hresp", bus.HRESP, 2'b00);
    check("rst_psel", bus.PSELx, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_hrdata", bus.HRDATA, 0);
    rst = 1'b0;
    idle_cycle(3);

    addr_phase(32'h1000_0004, 1'b1, 3'b010, 2'b10);
    data_phase(32'h1000_0004, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'hAAAA_5555, 0);
    idle_cycle(3);
    addr_phase(32'h3000_0010, 1'b0, 3'b010, 2'b10);
    data_phase(32'h3000_0010, 1'b0, 3'b010, 32'h0, 32'h1234_5678, 0);
    idle_cycle(0);
    addr_phase(32'h5000_0000, 1'b0, 3'b010, 2'b10);
    data_phase(32'h5000_0000, 1'b0, 3'b010, 32'h0, 32'hFFFF_0000, 0);
    idle_cycle(1);
    addr_phase(32'h2000_0008, 1'b1, 3'b011, 2'b10);
    data_phase(32'h2000_0008, 1'b1, 3'b011, 32'h0BAD_0BAD, 32'h0, 0);
    idle_cycle(2);

    addr_phase(32'h0000_0020, 1'b1, 3'b010, 2'b10);
    data_phase(32'h0000_0020, 1'b1, 3'b010, 32'hCAFE_0001, 32'h0, 0);
    addr_phase(32'h0000_0024, 1'b1, 3'b010, 2'b11);
    data_phase(32'h0000_0024, 1'b1, 3'b010, 32'hCAFE_0002, 32'h0, 0);
    check("b2b_state_ok", bus.HRESP, 2'b00);
    idle_cycle(3);

`ifdef APB_PREADY_EN
    addr_phase(32'h1000_0040, 1'b0, 3'b010, 2'b10);
    data_phase(32'h1000_0040, 1'b0, 3'b010, 32'h0, 32'h5A5A_A5A5, 3);
    idle_cycle(3);
`endif

    for (int t = 0; t < 40; t++) begin
      a  = {4'($urandom_range(0, 5)), 26'($urandom), 2'b00};
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      wd = $urandom;
      rd = $urandom;
      stall = 0;
`ifdef APB_PREADY_EN
      stall = $urandom_range(0, 2);
`endif
      repeat ($urandom_range(0, 2)) idle_cycle($urandom_range(0, 3));
      addr_phase(a, w, sz, $urandom_range(0, 1) ? 2'b10 : 2'b11);
      data_phase(a, w, sz, wd, rd, stall);
    end

    addr_phase(32'h2000_0000, 1'b1, 3'b010, 2'b10);
    @(negedge clk);
    drive_idle();
    bus.HWDATA = 32'h7777_8888;
    @(negedge clk);
    @(negedge clk);
    check("rstx_penable_before", bus.PENABLE, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0;
    exp_pwdata = '0;
    check("rstx_psel", bus.PSELx, 0);
    check("rstx_penable", bus.PENABLE, 0);
    check("rstx_hready", bus.HREADYout, 1);
    check("rstx_paddr", bus.PADDR, 0);
    check("rstx_hrdata", bus.HRDATA, 0);
    idle_cycle(3);
    addr_phase(32'h3000_0004, 1'b0, 3'b000, 2'b10);
    data_phase(32'h3000_0004, 1'b0, 3'b000, 32'h0, 32'h0F0F_F0F0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
